// File: rtl/dmem_arbiter.sv
// Shared data-memory port arbiter for a dual-issue pipeline. Pipe 1 is served before pipe 2 within a bundle.
// Optional watchdog: define DMEM_ARB_TIMEOUT_EN to enable the MAX_WAIT timeout counter and TimeoutErr.
module dmem_arbiter #(
   parameter int MAX_WAIT = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ReqM_1,
   input  logic        ReqM_2,
   input  logic        MemWriteM_1,
   input  logic        MemWriteM_2,
   input  logic [31:0] ALUOutM_1,
   input  logic [31:0] ALUOutM_2,
   input  logic [31:0] WriteDataM_1,
   input  logic [31:0] WriteDataM_2,
   input  logic        MemReady,
   input  logic [31:0] ReadDataM,
   output logic        MemoryUser,
   output logic        MemWriteOut,
   output logic        MemReadOut,
   output logic [31:0] AddrOut,
   output logic [31:0] WDataOut,
   output logic        StallMem,
   output logic        Done_1,
   output logic        Done_2,
   output logic [31:0] RData_1,
   output logic [31:0] RData_2,
   output logic        TimeoutErr
);

   typedef enum logic [1:0] {IDLE, ACCESS1, ACCESS2, RESP} state_t;

   state_t      state;
   logic        pend1, pend2;
   logic        write1, write2;
   logic [31:0] addr1, addr2;
   logic [31:0] wdata1, wdata2;

   if (MAX_WAIT < 1) begin : g_bad_max_wait
      $error("dmem_arbiter: MAX_WAIT must be at least 1");
   end

   // Hold the hazard unit off until the response cycle, where the whole bundle advances together.
   assign StallMem = (ReqM_1 | ReqM_2) & (state != RESP);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         pend1       <= 1'b0;
         pend2       <= 1'b0;
         write1      <= 1'b0;
         write2      <= 1'b0;
         addr1       <= '0;
         addr2       <= '0;
         wdata1      <= '0;
         wdata2      <= '0;
         MemoryUser  <= 1'b0;
         MemWriteOut <= 1'b0;
         MemReadOut  <= 1'b0;
         AddrOut     <= '0;
         WDataOut    <= '0;
         Done_1      <= 1'b0;
         Done_2      <= 1'b0;
         RData_1     <= '0;
         RData_2     <= '0;
      end else begin
         Done_1 <= 1'b0;
         Done_2 <= 1'b0;
         case (state)
            IDLE: begin
               pend1  <= ReqM_1;
               pend2  <= ReqM_2;
               write1 <= MemWriteM_1;
               write2 <= MemWriteM_2;
               addr1  <= ALUOutM_1;
               addr2  <= ALUOutM_2;
               wdata1 <= WriteDataM_1;
               wdata2 <= WriteDataM_2;
               if (ReqM_1) begin
                  state       <= ACCESS1;
                  MemoryUser  <= 1'b0;
                  MemWriteOut <= MemWriteM_1;
                  MemReadOut  <= ~MemWriteM_1;
                  AddrOut     <= ALUOutM_1;
                  WDataOut    <= WriteDataM_1;
               end else if (ReqM_2) begin
                  state       <= ACCESS2;
                  MemoryUser  <= 1'b1;
                  MemWriteOut <= MemWriteM_2;
                  MemReadOut  <= ~MemWriteM_2;
                  AddrOut     <= ALUOutM_2;
                  WDataOut    <= WriteDataM_2;
               end
            end
            ACCESS1: begin
               if (MemReady) begin
                  if (!write1) RData_1 <= ReadDataM;
                  if (pend2) begin
                     state       <= ACCESS2;
                     MemoryUser  <= 1'b1;
                     MemWriteOut <= write2;
                     MemReadOut  <= ~write2;
                     AddrOut     <= addr2;
                     WDataOut    <= wdata2;
                  end else begin
                     state       <= RESP;
                     MemoryUser  <= 1'b0;
                     MemWriteOut <= 1'b0;
                     MemReadOut  <= 1'b0;
                     Done_1      <= pend1;
                     Done_2      <= pend2;
                  end
               end
            end
            ACCESS2: begin
               if (MemReady) begin
                  if (!write2) RData_2 <= ReadDataM;
                  state       <= RESP;
                  MemoryUser  <= 1'b0;
                  MemWriteOut <= 1'b0;
                  MemReadOut  <= 1'b0;
                  Done_1      <= pend1;
                  Done_2      <= pend2;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef DMEM_ARB_TIMEOUT_EN
   localparam int CW = $clog2(MAX_WAIT + 1);

   logic [CW-1:0] wait_cnt;
   logic [CW-1:0] wait_cnt_next;
   logic          access_entry;
   logic          waiting;

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
      return (c == {CW{1'b1}}) ? c : c + 1'b1;
   endfunction

   // A new access starts either from IDLE or on the hand-over from pipe 1 to pipe 2.
   assign access_entry  = ((state == IDLE) && (ReqM_1 || ReqM_2)) ||
                          ((state == ACCESS1) && MemReady && pend2);
   assign waiting       = ((state == ACCESS1) || (state == ACCESS2)) && !MemReady;
   assign wait_cnt_next = sat_inc(wait_cnt);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wait_cnt   <= '0;
         TimeoutErr <= 1'b0;
      end else if (access_entry) begin
         wait_cnt <= '0;
      end else if (waiting) begin
         wait_cnt <= wait_cnt_next;
         if (wait_cnt_next == CW'(MAX_WAIT)) TimeoutErr <= 1'b1;
      end
   end
`else
   assign TimeoutErr = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: expected Done bundles are queued at issue and popped on Done pulses.
module tb_dmem_arbiter;

   logic        clk;
   logic        reset;
   logic        ReqM_1, ReqM_2;
   logic        MemWriteM_1, MemWriteM_2;
   logic [31:0] ALUOutM_1, ALUOutM_2;
   logic [31:0] WriteDataM_1, WriteDataM_2;
   logic        MemReady;
   logic [31:0] ReadDataM;
   logic        MemoryUser, MemWriteOut, MemReadOut;
   logic [31:0] AddrOut, WDataOut;
   logic        StallMem, Done_1, Done_2;
   logic [31:0] RData_1, RData_2;
   logic        TimeoutErr;

`ifdef DMEM_ARB_TIMEOUT_EN
   localparam logic TO_EN = 1'b1;
`else
   localparam logic TO_EN = 1'b0;
`endif

   typedef struct {
      logic        d1;
      logic        d2;
      logic [31:0] r1;
      logic [31:0] r2;
   } exp_t;

   exp_t        sb[$];
   int          tests = 0;
   int          fails = 0;
   logic [31:0] exp_rd1 = 32'h0;
   logic [31:0] exp_rd2 = 32'h0;

   dmem_arbiter #(.MAX_WAIT(15)) dut (
      .clk(clk), .reset(reset),
      .ReqM_1(ReqM_1), .ReqM_2(ReqM_2),
      .MemWriteM_1(MemWriteM_1), .MemWriteM_2(MemWriteM_2),
      .ALUOutM_1(ALUOutM_1), .ALUOutM_2(ALUOutM_2),
      .WriteDataM_1(WriteDataM_1), .WriteDataM_2(WriteDataM_2),
      .MemReady(MemReady), .ReadDataM(ReadDataM),
      .MemoryUser(MemoryUser), .MemWriteOut(MemWriteOut), .MemReadOut(MemReadOut),
      .AddrOut(AddrOut), .WDataOut(WDataOut), .StallMem(StallMem),
      .Done_1(Done_1), .Done_2(Done_2),
      .RData_1(RData_1), .RData_2(RData_2),
      .TimeoutErr(TimeoutErr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Every Done pulse must match the oldest queued bundle; a pulse with nothing queued is an error.
   always @(negedge clk) begin
      if (Done_1 || Done_2) begin
         tests++;
         if (sb.size() == 0) begin
            fails++;
            $display("FAIL sb_unexpected_done: got Done_1=%0b Done_2=%0b, expected no Done", Done_1, Done_2);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if ({Done_1, Done_2, RData_1, RData_2} !== {e.d1, e.d2, e.r1, e.r2}) begin
               fails++;
               $display("FAIL sb_done: got d1=%0b d2=%0b r1=%h r2=%h, expected d1=%0b d2=%0b r1=%h r2=%h",
                        Done_1, Done_2, RData_1, RData_2, e.d1, e.d2, e.r1, e.r2);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic d1, input logic d2);
      exp_t e;
      e.d1 = d1; e.d2 = d2; e.r1 = exp_rd1; e.r2 = exp_rd2;
      sb.push_back(e);
   endtask

   task automatic clear_inputs();
      ReqM_1 = 0; ReqM_2 = 0; MemWriteM_1 = 0; MemWriteM_2 = 0;
      ALUOutM_1 = 0; ALUOutM_2 = 0; WriteDataM_1 = 0; WriteDataM_2 = 0;
      MemReady = 0; ReadDataM = 0;
   endtask

   task automatic check_zero_outputs(input string name);
      tests++;
      if ({MemoryUser, MemWriteOut, MemReadOut, AddrOut, WDataOut, Done_1, Done_2, RData_1, RData_2, TimeoutErr} !== '0) begin
         fails++;
         $display("FAIL %s: got user=%0b wr=%0b rd=%0b addr=%h wd=%h d1=%0b d2=%0b r1=%h r2=%h to=%0b, expected all zero",
                  name, MemoryUser, MemWriteOut, MemReadOut, AddrOut, WDataOut, Done_1, Done_2, RData_1, RData_2, TimeoutErr);
      end
   endtask

   task automatic test_reset();
      clear_inputs();
      reset = 0;
      #1;
      check_zero_outputs("reset_outputs");
      tick(); tick();
      reset = 1;
      tick();
      tests++;
      if (StallMem !== 1'b0) begin
         fails++;
         $display("FAIL reset_stall: got %0b, expected 0", StallMem);
      end
   endtask

   task automatic test_single_store();
      int wr_cycles = 0;
      ReqM_1 = 1; MemWriteM_1 = 1; ALUOutM_1 = 32'h10; WriteDataM_1 = 32'hDEADBEEF;
      push_exp(1'b1, 1'b0);
      #1;
      tests++;
      if (StallMem !== 1'b1) begin
         fails++;
         $display("FAIL store_stall_idle: got %0b, expected 1", StallMem);
      end
      tick();
      tests++;
      if ({MemoryUser, MemReadOut, AddrOut, WDataOut} !== {1'b0, 1'b0, 32'h10, 32'hDEADBEEF}) begin
         fails++;
         $display("FAIL store_access: got user=%0b rd=%0b addr=%h wd=%h, expected user=0 rd=0 addr=00000010 wd=deadbeef",
                  MemoryUser, MemReadOut, AddrOut, WDataOut);
      end
      if (MemWriteOut) wr_cycles++;
      tick();
      if (MemWriteOut) wr_cycles++;
      MemReady = 1;
      tick();
      MemReady = 0;
      if (MemWriteOut) wr_cycles++;
      tests++;
      if (wr_cycles != 2) begin
         fails++;
         $display("FAIL store_write_cycles: got %0d, expected 2", wr_cycles);
      end
      tests++;
      if ({Done_1, Done_2, StallMem} !== 3'b100) begin
         fails++;
         $display("FAIL store_resp: got d1=%0b d2=%0b stall=%0b, expected d1=1 d2=0 stall=0", Done_1, Done_2, StallMem);
      end
      tick();
      clear_inputs();
      tick();
   endtask

   task automatic test_dual_order();
      ReqM_1 = 1; MemWriteM_1 = 1; ALUOutM_1 = 32'h20; WriteDataM_1 = 32'h12345678;
      ReqM_2 = 1; MemWriteM_2 = 0; ALUOutM_2 = 32'h20; WriteDataM_2 = 32'hFFFFFFFF;
      exp_rd2 = 32'h12345678;
      push_exp(1'b1, 1'b1);
      tick();
      tests++;
      if ({MemoryUser, MemWriteOut, MemReadOut, AddrOut} !== {1'b0, 1'b1, 1'b0, 32'h20}) begin
         fails++;
         $display("FAIL dual_first: got user=%0b wr=%0b rd=%0b addr=%h, expected user=0 wr=1 rd=0 addr=00000020",
                  MemoryUser, MemWriteOut, MemReadOut, AddrOut);
      end
      MemReady = 1;
      tick();
      tests++;
      if ({MemoryUser, MemWriteOut, MemReadOut, AddrOut, StallMem} !== {1'b1, 1'b0, 1'b1, 32'h20, 1'b1}) begin
         fails++;
         $display("FAIL dual_second: got user=%0b wr=%0b rd=%0b addr=%h stall=%0b, expected user=1 wr=0 rd=1 addr=00000020 stall=1",
                  MemoryUser, MemWriteOut, MemReadOut, AddrOut, StallMem);
      end
      ReadDataM = 32'h12345678;
      tick();
      MemReady = 0; ReadDataM = 0;
      tests++;
      if ({Done_1, Done_2, RData_2, StallMem} !== {1'b1, 1'b1, 32'h12345678, 1'b0}) begin
         fails++;
         $display("FAIL dual_resp: got d1=%0b d2=%0b r2=%h stall=%0b, expected d1=1 d2=1 r2=12345678 stall=0",
                  Done_1, Done_2, RData_2, StallMem);
      end
      tick();
      clear_inputs();
      tick();
   endtask

   task automatic test_pipe2_wait();
      int bad = 0;
      ReqM_2 = 1; MemWriteM_2 = 0; ALUOutM_2 = 32'h44;
      exp_rd2 = 32'hCAFEF00D;
      push_exp(1'b0, 1'b1);
      tick();
      for (int i = 0; i < 4; i++) begin
         // Late pipe-1 request arriving mid-access must be ignored.
         ReqM_1 = (i == 1);
         ALUOutM_2 = 32'h99;
         #1;
         if ({MemoryUser, MemReadOut, MemWriteOut, AddrOut, StallMem} !== {1'b1, 1'b1, 1'b0, 32'h44, 1'b1}) bad++;
         if (i == 3) begin
            MemReady = 1; ReadDataM = 32'hCAFEF00D;
         end
         tick();
      end
      MemReady = 0; ReadDataM = 0;
      tests++;
      if (bad != 0) begin
         fails++;
         $display("FAIL p2_wait_hold: got %0d bad cycles, expected 0", bad);
      end
      tests++;
      if ({Done_1, Done_2, RData_2, StallMem, MemReadOut} !== {1'b0, 1'b1, 32'hCAFEF00D, 1'b0, 1'b0}) begin
         fails++;
         $display("FAIL p2_resp: got d1=%0b d2=%0b r2=%h stall=%0b rd=%0b, expected d1=0 d2=1 r2=cafef00d stall=0 rd=0",
                  Done_1, Done_2, RData_2, StallMem, MemReadOut);
      end
      tick();
      clear_inputs();
      tick();
   endtask

   task automatic test_reset_mid_access();
      ReqM_2 = 1; MemWriteM_2 = 1; ALUOutM_2 = 32'h30; WriteDataM_2 = 32'hA5A5A5A5;
      tick();
      tick();
      reset = 0;
      #1;
      exp_rd1 = 0; exp_rd2 = 0;
      check_zero_outputs("reset_mid_access");
      clear_inputs();
      tick();
      reset = 1;
      for (int i = 0; i < 4; i++) begin
         MemReady = (i % 2 == 0);
         tick();
      end
      MemReady = 0;
      ReqM_1 = 1; MemWriteM_1 = 0; ALUOutM_1 = 32'h80;
      exp_rd1 = 32'h55AA55AA;
      push_exp(1'b1, 1'b0);
      tick();
      MemReady = 1; ReadDataM = 32'h55AA55AA;
      tick();
      MemReady = 0; ReadDataM = 0;
      tests++;
      if ({Done_1, RData_1} !== {1'b1, 32'h55AA55AA}) begin
         fails++;
         $display("FAIL post_reset_min_latency: got d1=%0b r1=%h, expected d1=1 r1=55aa55aa", Done_1, RData_1);
      end
      tick();
      clear_inputs();
      tick();
   endtask

   task automatic test_timeout();
      logic to14, to17;
      ReqM_1 = 1; MemWriteM_1 = 0; ALUOutM_1 = 32'h100;
      exp_rd1 = 32'h0BADF00D;
      push_exp(1'b1, 1'b0);
      to14 = 1'bx; to17 = 1'bx;
      for (int c = 0; c <= 20; c++) begin
         if (c == 14) to14 = TimeoutErr;
         if (c == 17) to17 = TimeoutErr;
         tick();
      end
      MemReady = 1; ReadDataM = 32'h0BADF00D;
      tick();
      MemReady = 0; ReadDataM = 0;
      tests++;
      if (to14 !== 1'b0) begin
         fails++;
         $display("FAIL timeout_early: got %0b, expected 0", to14);
      end
      tests++;
      if (to17 !== TO_EN) begin
         fails++;
         $display("FAIL timeout_flag: got %0b, expected %0b", to17, TO_EN);
      end
      tick();
      clear_inputs();
      tick(); tick();
      tests++;
      if (TimeoutErr !== TO_EN) begin
         fails++;
         $display("FAIL timeout_sticky: got %0b, expected %0b", TimeoutErr, TO_EN);
      end
   endtask

   task automatic test_idle_memready();
      int bad = 0;
      for (int i = 0; i < 5; i++) begin
         MemReady = 1; ReadDataM = 32'hFFFF0000 | i;
         #1;
         if ({MemWriteOut, MemReadOut, MemoryUser, StallMem} !== 4'b0000) bad++;
         tick();
      end
      MemReady = 0; ReadDataM = 0;
      tick();
      tests++;
      if (bad != 0) begin
         fails++;
         $display("FAIL idle_memready: got %0d bad cycles, expected 0", bad);
      end
      tests++;
      if ({RData_1, RData_2, Done_1, Done_2} !== {exp_rd1, exp_rd2, 2'b00}) begin
         fails++;
         $display("FAIL idle_rdata: got r1=%h r2=%h, expected r1=%h r2=%h", RData_1, RData_2, exp_rd1, exp_rd2);
      end
   endtask

   initial begin
      test_reset();
      test_single_store();
      test_dual_order();
      test_pipe2_wait();
      test_reset_mid_access();
      test_timeout();
      test_idle_memready();
      tick(); tick();
      tests++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL sb_drain: got %0d pending Done bundles, expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
